bitscan_unit: RTL
=================

BITSCAN_UNIT -- requirements
Module: bitscan_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be a power of two, 8..64.
REQ-002 Parameter TAG_W, default 5, width of the sideband tag carried with each operation.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  synchronous kill of all in-flight operations.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit accepts a request this cycle.
REQ-008 in_op  input  2  operation code, bitscan_op_t (CTZ=0, CLZ=1, CPOP=2, reserved=3).
REQ-009 in_opnd  input  WIDTH  operand.
REQ-010 in_tag  input  TAG_W  sideband tag, returned unmodified.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 out_res  output  WIDTH  result, zero-extended count.
REQ-014 out_tag  output  TAG_W  tag of the result.
REQ-015 out_illegal  output  1  op was reserved or compiled out.

Function
REQ-016 A transfer SHALL occur on an input or output port only in a cycle where valid and ready are both high.
REQ-017 Two-stage pipeline: S1 registers op, tag, the isolated lowest set bit (CTZ) or the isolated highest set bit (CLZ), a zero flag, and per-byte popcounts (CPOP); S2 registers the encoded result.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready stays high; throughput SHALL be one op per cycle.
REQ-019 Each stage advances when it is empty or its contents move on this cycle; in_ready = !s1_valid | s1_advance, where s1_advance = !s2_valid | out_ready (no combinational path from in_valid to in_ready).
REQ-020 While out_valid=1 and out_ready=0, out_res, out_tag and out_illegal SHALL hold stable.
REQ-021 CTZ: out_res = index of the lowest set bit; CLZ: out_res = WIDTH-1 minus the index of the highest set bit.
REQ-022 Operand zero: CTZ and CLZ SHALL return WIDTH (e.g. 32); CPOP SHALL return 0.
REQ-023 CPOP: out_res = number of set bits, 0..WIDTH.
REQ-024 Reserved op: out_res=0, out_illegal=1, tag still returned, and the request SHALL occupy one pipeline slot.
REQ-025 flush=1 SHALL clear s1_valid and s2_valid at the next edge; a request presented in the same cycle SHALL be dropped, and in_ready SHALL be 0 during flush.
REQ-026 The count width is $clog2(WIDTH)+1 bits; the upper bits of out_res SHALL be zero.

Reset
REQ-027 With rst_n=0 at a clock edge: s1_valid=0, s2_valid=0, out_valid=0, out_res=0, out_tag=0, out_illegal=0; in_ready SHALL be 0 during reset.
REQ-028 Reset mid-operation SHALL discard all in-flight requests; none SHALL emerge after reset is released.
REQ-029 Data registers other than the outputs need no reset.

Configuration
REQ-030 Macro BITSCAN_CPOP_EN: when defined, the CPOP datapath SHALL be built and CPOP SHALL behave as in REQ-023.
REQ-031 When BITSCAN_CPOP_EN is undefined, no popcount logic SHALL be synthesised, and CPOP SHALL be treated as reserved (REQ-024).

Structure
REQ-032 Package bitscan_pkg SHALL hold bitscan_op_t and the op encodings; count-width helper functions also belong there.
REQ-033 Sub-module bitscan_enc (parameter WIDTH) SHALL convert a one-hot vector to a binary index using OR-reduction over index bits; it is instantiated once in S2 for CTZ/CLZ.
REQ-034 The S1 isolation for CLZ SHALL use a bit reversal feeding the same lowest-bit isolation as CTZ (x & -x).

Verification (WIDTH=32 unless stated)
REQ-035 CTZ 0x0000_0008, CLZ 0x0000_0008, CTZ 0x0 back-to-back with out_ready=1 -> results 3, 28, 32 on consecutive cycles, each 2 cycles after its input.
REQ-036 CPOP 0xF0F0_0001 with the macro defined -> 9; without the macro -> out_res 0, out_illegal=1.
REQ-037 Four ops issued while out_ready=0 -> in_ready drops after 2 accepted; out_res holds stable; releasing out_ready drains in order with tags 1,2,3,4 intact.
REQ-038 flush asserted with 2 ops in flight plus in_valid=1 -> no out_valid for any of the 3; the next op returns correctly 2 cycles later.
REQ-039 rst_n low for 1 cycle with the pipe full -> all outputs 0 after the edge; no stale result afterwards.
REQ-040 WIDTH=64, CLZ 0x1 -> 63; CTZ 0x8000_0000_0000_0000 -> 63; CTZ 0 -> 64.

Source files
------------

// File: rtl/bitscan_pkg.sv
// bitscan_pkg: operation encodings and count-width helper shared by the
// bitscan unit and its encoder.
package bitscan_pkg;

  typedef enum logic [1:0] {
    OP_CTZ  = 2'd0,
    OP_CLZ  = 2'd1,
    OP_CPOP = 2'd2,
    OP_RSVD = 2'd3
  } bitscan_op_t;

  // Bits needed to hold a count of 0..w inclusive.
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/bitscan_enc.sv
// bitscan_enc: one-hot to binary index encoder. Each index bit is the
// OR of the one-hot lines whose position has that bit set.
module bitscan_enc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         onehot_i,
  output logic [$clog2(WIDTH)-1:0] idx_o
);

  localparam int IW = $clog2(WIDTH);

  // Positions whose binary index has bit b set.
  function automatic logic [WIDTH-1:0] sel_mask(input int b);
    logic [WIDTH-1:0] m;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = ((i >> b) & 1) == 1;
    end
    return m;
  endfunction

  for (genvar gi = 0; gi < IW; gi++) begin : g_idx
    localparam logic [WIDTH-1:0] MASK = sel_mask(gi);
    assign idx_o[gi] = |(onehot_i & MASK);
  end

endmodule

// File: rtl/bitscan_unit.sv
// bitscan_unit: two-stage CTZ / CLZ / CPOP pipeline with valid/ready
// handshakes on both sides. S1 isolates a single bit (CLZ reuses the CTZ
// isolation on the bit-reversed operand) and, when built, per-byte
// popcounts; S2 encodes the result. Define BITSCAN_CPOP_EN to build the
// popcount datapath; otherwise CPOP is reported as illegal.
module bitscan_unit
  import bitscan_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_opnd,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int IW = $clog2(WIDTH);

  bitscan_op_t      op_in;
  logic [WIDTH-1:0] opnd_rev;
  logic [WIDTH-1:0] scan_src;
  logic [WIDTH-1:0] onehot_d;
  logic             s1_advance;
  logic             in_fire;

  logic             s1_valid_q;
  bitscan_op_t      s1_op_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [WIDTH-1:0] s1_onehot_q;
  logic             s1_zero_q;

  logic [IW-1:0]    enc_idx;
  logic [WIDTH-1:0] res_d;
  logic             illegal_d;

  logic             s2_valid_q;
  logic [WIDTH-1:0] out_res_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_illegal_q;

  assign op_in      = bitscan_op_t'(in_op);
  assign s1_advance = !s2_valid_q || out_ready;
  assign in_ready   = rst_n && !flush && (!s1_valid_q || s1_advance);
  assign in_fire    = in_valid && in_ready;

  // CLZ of x equals CTZ of bit-reversed x, so one isolation path serves both.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
    assign opnd_rev[gi] = in_opnd[WIDTH-1-gi];
  end

  assign scan_src = (op_in == OP_CLZ) ? opnd_rev : in_opnd;
  assign onehot_d = scan_src & (~scan_src + WIDTH'(1));

`ifdef BITSCAN_CPOP_EN
  localparam int CW = cnt_w(WIDTH);
  localparam int NB = WIDTH / 8;

  logic [NB-1:0][3:0] bytecnt_d;
  logic [NB-1:0][3:0] s1_bytecnt_q;
  logic [CW-1:0]      pop_sum;

  for (genvar gi = 0; gi < NB; gi++) begin : g_bytecnt
    logic [3:0] cnt;
    // Population count of one operand byte (0..8).
    always_comb begin
      cnt = '0;
      for (int k = 0; k < 8; k++) begin
        cnt = cnt + {3'b000, in_opnd[gi*8+k]};
      end
    end
    assign bytecnt_d[gi] = cnt;
  end

  // Per-byte counts captured alongside the rest of S1.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_bytecnt_q <= bytecnt_d;
    end
  end

  // Sum of byte counts in S2.
  always_comb begin
    pop_sum = '0;
    for (int k = 0; k < NB; k++) begin
      pop_sum = pop_sum + CW'(s1_bytecnt_q[k]);
    end
  end
`endif

  // S1 payload; no reset needed since it is qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_op_q     <= op_in;
      s1_tag_q    <= in_tag;
      s1_onehot_q <= onehot_d;
      s1_zero_q   <= (in_opnd == '0);
    end
  end

  bitscan_enc #(
    .WIDTH(WIDTH)
  ) u_enc (
    .onehot_i(s1_onehot_q),
    .idx_o   (enc_idx)
  );

  // S2 result selection; zero operand gives WIDTH for CTZ/CLZ.
  always_comb begin
    res_d     = '0;
    illegal_d = 1'b0;
    case (s1_op_q)
      OP_CTZ, OP_CLZ: res_d = s1_zero_q ? WIDTH'(WIDTH) : WIDTH'(enc_idx);
`ifdef BITSCAN_CPOP_EN
      OP_CPOP:        res_d = WIDTH'(pop_sum);
`endif
      default:        illegal_d = 1'b1;
    endcase
  end

  // Stage occupancy and output registers; flush empties both stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      out_res_q     <= '0;
      out_tag_q     <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
      end else begin
        if (!s1_valid_q || s1_advance) begin
          s1_valid_q <= in_fire;
        end
        if (s1_advance) begin
          s2_valid_q <= s1_valid_q;
        end
      end
      if (s1_valid_q && s1_advance) begin
        out_res_q     <= res_d;
        out_tag_q     <= s1_tag_q;
        out_illegal_q <= illegal_d;
      end
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_res     = out_res_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_illegal_q;

endmodule
